// File: rtl/qix_pkg.sv
// qix_pkg: shared constants and write-priority ranking for the qix shared-memory block
package qix_pkg;
  localparam int QIX_MAX_PORTS = 4;
  localparam int QIX_TGT_W = 2;
  function automatic int qix_rank(input int port, input int hi, input int n);
    return port >= n ? n : port == hi ? 0 : port < hi ? port + 1 : port;
  endfunction
endpackage

// File: rtl/qix_firq_mbox.sv
// qix_firq_mbox: per-port latched FIRQ flags, set by any other port and cleared by the owner's ack
module qix_firq_mbox import qix_pkg::*; #(
  parameter int NPORTS = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NPORTS-1:0]             firq_set,
  input  logic [NPORTS*QIX_TGT_W-1:0]   firq_tgt,
  input  logic [NPORTS-1:0]             firq_ack,
  output logic [NPORTS-1:0]             firq_n
);
  logic [NPORTS-1:0] pending, set;
  always_comb begin
    set = '0;
    for (int i = 0; i < NPORTS; i++)
      for (int j = 0; j < NPORTS; j++)
        if (firq_set[i] && i != j && firq_tgt[i*QIX_TGT_W +: QIX_TGT_W] == QIX_TGT_W'(j)) set[j] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pending <= '0;
    else pending <= set | (pending & ~firq_ack);
  assign firq_n = ~pending;
endmodule

// File: rtl/qix_shared_mem.sv
// qix_shared_mem: N-port shared RAM with priority write arbitration, read-first registered reads, collision counter and FIRQ mailbox
module qix_shared_mem import qix_pkg::*; #(
  parameter int NPORTS  = 2,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int HI_PRIO = 0
) (
  input  logic                          clk_20m,
  input  logic                          reset_n,
  input  logic [NPORTS-1:0]             req,
  input  logic [NPORTS-1:0]             we,
  input  logic [NPORTS*ADDR_W-1:0]      addr,
  input  logic [NPORTS*DATA_W-1:0]      wdata,
  output logic [NPORTS*DATA_W-1:0]      rdata,
  output logic [NPORTS-1:0]             rvalid,
  input  logic [NPORTS-1:0]             firq_set,
  input  logic [NPORTS*QIX_TGT_W-1:0]   firq_tgt,
  input  logic [NPORTS-1:0]             firq_ack,
  output logic [NPORTS-1:0]             firq_n,
  output logic [7:0]                    coll_cnt
);
  logic [1:0] rst_sync;
  logic rst_n;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [NPORTS-1:0] wr, win;
  logic [2:0] losses;
  logic [8:0] cnt_sum;
  always_ff @(posedge clk_20m or negedge reset_n)
    if (!reset_n) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];
  always_comb begin
    wr = req & we;
    win = wr;
    losses = '0;
    for (int i = 0; i < NPORTS; i++)
      for (int j = 0; j < NPORTS; j++)
        if (j != i && wr[j] && addr[j*ADDR_W +: ADDR_W] == addr[i*ADDR_W +: ADDR_W] &&
            qix_rank(j, HI_PRIO, NPORTS) < qix_rank(i, HI_PRIO, NPORTS)) win[i] = 1'b0;
    for (int i = 0; i < NPORTS; i++) losses = losses + 3'(wr[i] & ~win[i]);
  end
  assign cnt_sum = {1'b0, coll_cnt} + 9'(losses);
  always_ff @(posedge clk_20m)
    for (int i = 0; i < NPORTS; i++)
      if (rst_n && win[i]) mem[addr[i*ADDR_W +: ADDR_W]] <= wdata[i*DATA_W +: DATA_W];
  always_ff @(posedge clk_20m or negedge rst_n)
    if (!rst_n) begin
      rdata <= '0;
      rvalid <= '0;
      coll_cnt <= '0;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        rvalid[i] <= req[i] & ~we[i];
        if (req[i] && !we[i]) rdata[i*DATA_W +: DATA_W] <= mem[addr[i*ADDR_W +: ADDR_W]];
      end
      coll_cnt <= cnt_sum[8] ? 8'hff : cnt_sum[7:0];
    end
  qix_firq_mbox #(.NPORTS(NPORTS)) u_mbox (
    .clk(clk_20m),
    .rst_n(rst_n),
    .firq_set(firq_set),
    .firq_tgt(firq_tgt),
    .firq_ack(firq_ack),
    .firq_n(firq_n)
  );
endmodule

// File: tb/tb_qix_shared_mem.sv
// tb_qix_shared_mem: scoreboard bench for 2-port (HI_PRIO=1) and 3-port (HI_PRIO=0) instances
module tb_qix_shared_mem;
  logic clk_20m = 1'b0;
  always #5 clk_20m = ~clk_20m;
  logic reset_n;
  logic [1:0] req2, we2, rvalid2, fset2, fack2, firqn2;
  logic [19:0] addr2;
  logic [15:0] wdata2, rdata2;
  logic [3:0] ftgt2;
  logic [7:0] coll2;
  logic [2:0] req3, we3, rvalid3, fset3, fack3, firqn3;
  logic [29:0] addr3;
  logic [23:0] wdata3, rdata3;
  logic [5:0] ftgt3;
  logic [7:0] coll3;
  logic [4:0] rv_all;
  logic [39:0] rd_all;
  logic [7:0] mon_exp, mon_act;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] exp_q [5][$];
  assign rv_all = {rvalid3, rvalid2};
  assign rd_all = {rdata3, rdata2};
  qix_shared_mem #(.NPORTS(2), .HI_PRIO(1)) u2 (
    .clk_20m(clk_20m), .reset_n(reset_n), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
    .rdata(rdata2), .rvalid(rvalid2), .firq_set(fset2), .firq_tgt(ftgt2), .firq_ack(fack2),
    .firq_n(firqn2), .coll_cnt(coll2)
  );
  qix_shared_mem #(.NPORTS(3), .HI_PRIO(0)) u3 (
    .clk_20m(clk_20m), .reset_n(reset_n), .req(req3), .we(we3), .addr(addr3), .wdata(wdata3),
    .rdata(rdata3), .rvalid(rvalid3), .firq_set(fset3), .firq_tgt(ftgt3), .firq_ack(fack3),
    .firq_n(firqn3), .coll_cnt(coll3)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  always @(negedge clk_20m)
    for (int p = 0; p < 5; p++)
      if (rv_all[p]) begin
        n_cmp++;
        if (exp_q[p].size() == 0) begin
          n_bad++;
          $display("FAIL rd_unexpected port%0d: got rvalid=1 want 0", p);
        end else begin
          mon_exp = exp_q[p].pop_front();
          mon_act = rd_all[p*8 +: 8];
          if (mon_act !== mon_exp) begin
            n_bad++;
            $display("FAIL rd_data port%0d: got %0h want %0h", p, mon_act, mon_exp);
          end
        end
      end
  task automatic tick;
    @(posedge clk_20m);
    #1;
  endtask
  task automatic clr;
    req2 = '0; we2 = '0; fset2 = '0; fack2 = '0;
    req3 = '0; we3 = '0; fset3 = '0; fack3 = '0;
  endtask
  task automatic wr2(input int p, input logic [9:0] a, input logic [7:0] d);
    req2[p] = 1'b1; we2[p] = 1'b1; addr2[p*10 +: 10] = a; wdata2[p*8 +: 8] = d;
  endtask
  task automatic rd2(input int p, input logic [9:0] a, input logic [7:0] e);
    req2[p] = 1'b1; we2[p] = 1'b0; addr2[p*10 +: 10] = a; exp_q[p].push_back(e);
  endtask
  task automatic wr3(input int p, input logic [9:0] a, input logic [7:0] d);
    req3[p] = 1'b1; we3[p] = 1'b1; addr3[p*10 +: 10] = a; wdata3[p*8 +: 8] = d;
  endtask
  task automatic rd3(input int p, input logic [9:0] a, input logic [7:0] e);
    req3[p] = 1'b1; we3[p] = 1'b0; addr3[p*10 +: 10] = a; exp_q[2+p].push_back(e);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    clr;
    addr2 = '0; wdata2 = '0; ftgt2 = '0; addr3 = '0; wdata3 = '0; ftgt3 = '0;
    reset_n = 1'b0;
    repeat (3) tick;
    chk("rst_rdata", 32'(rdata2), 0);
    chk("rst_rvalid", 32'(rvalid2), 0);
    chk("rst_firq_n2", 32'(firqn2), 32'h3);
    chk("rst_coll", 32'(coll2), 0);
    chk("rst_firq_n3", 32'(firqn3), 32'h7);
    reset_n = 1'b1;
    repeat (4) tick;
    wr2(0, 10'h3ff, 8'ha5); tick; clr;
    rd2(1, 10'h3ff, 8'ha5); tick; clr;
    tick;
    wr2(0, 10'h010, 8'h22); tick; clr;
    wr2(0, 10'h010, 8'h11); rd2(1, 10'h010, 8'h22); tick; clr;
    rd2(1, 10'h010, 8'h11); tick; clr;
    tick;
    wr2(0, 10'h020, 8'h55); wr2(1, 10'h020, 8'h66); tick; clr;
    chk("coll_one", 32'(coll2), 1);
    rd2(0, 10'h020, 8'h66); tick; clr;
    wr2(0, 10'h020, 8'h01); wr2(1, 10'h020, 8'h02); repeat (6) tick; clr;
    chk("coll_seven", 32'(coll2), 7);
    wr2(0, 10'h030, 8'h77); wr2(1, 10'h031, 8'h88); tick; clr;
    chk("coll_distinct", 32'(coll2), 7);
    rd2(0, 10'h031, 8'h88); rd2(1, 10'h030, 8'h77); tick; clr;
    fset2 = 2'b01; ftgt2 = 4'b0001; tick; clr;
    chk("firq_set", 32'(firqn2), 32'h1);
    fset2 = 2'b01; fack2 = 2'b10; tick; clr;
    chk("firq_set_over_ack", 32'(firqn2), 32'h1);
    fack2 = 2'b10; tick; clr;
    chk("firq_ack", 32'(firqn2), 32'h3);
    fset2 = 2'b10; ftgt2 = 4'b0000; tick; clr;
    chk("firq_pend0", 32'(firqn2), 32'h2);
    chk("coll_pre_rst", 32'(coll2), 7);
    req2[1] = 1'b1; we2[1] = 1'b0; addr2[19:10] = 10'h030; tick; clr;
    chk("pre_rst_rvalid", 32'(rvalid2), 32'h2);
    #2 reset_n = 1'b0;
    #1;
    chk("async_firq_n", 32'(firqn2), 32'h3);
    chk("async_coll", 32'(coll2), 0);
    chk("async_rvalid", 32'(rvalid2), 0);
    repeat (2) tick;
    reset_n = 1'b1;
    repeat (4) tick;
    wr2(0, 10'h020, 8'h55); wr2(1, 10'h020, 8'h66); repeat (300) tick; clr;
    chk("coll_saturate", 32'(coll2), 255);
    rd2(0, 10'h020, 8'h66); tick; clr;
    fset3 = 3'b100; ftgt3 = 6'b100000; tick; clr;
    chk("firq_self", 32'(firqn3), 32'h7);
    fset3 = 3'b100; ftgt3 = 6'b110000; tick; clr;
    chk("firq_range", 32'(firqn3), 32'h7);
    fset3 = 3'b011; ftgt3 = 6'b001010; tick; clr;
    chk("firq_multi", 32'(firqn3), 32'h3);
    fack3 = 3'b100; tick; clr;
    chk("firq_multi_ack", 32'(firqn3), 32'h7);
    wr3(0, 10'h040, 8'h10); wr3(1, 10'h040, 8'h20); wr3(2, 10'h040, 8'h30); tick; clr;
    chk("coll3_three", 32'(coll3), 2);
    wr3(1, 10'h041, 8'h41); wr3(2, 10'h041, 8'h42); tick; clr;
    chk("coll3_pair", 32'(coll3), 3);
    rd3(2, 10'h040, 8'h10); rd3(0, 10'h041, 8'h41); tick; clr;
    repeat (3) tick;
    for (int p = 0; p < 5; p++) chk($sformatf("rd_missing port%0d", p), 32'(exp_q[p].size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/qix_shared_mem.md
# qix_shared_mem

Parametrised shared-RAM and FIRQ mailbox for multi-CPU Qix-family boards, sitting between the data, video and (optional) further CPU boards at platform top level. It generalises the fixed two-port 1KB shared RAM and hard-wired FIRQ cross-signals to N ports. It adds deterministic write-collision arbitration, registered read-first reads, and latched, acknowledged FIRQ requests with a collision counter.

## Interface
- NPORTS, 2: number of CPU ports (2..4).
- ADDR_W, 10: RAM address width; depth = 2**ADDR_W bytes.
- DATA_W, 8: data width.
- HI_PRIO, 0: port index that wins write-write collisions; remaining ports rank by ascending index.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- clk_20m  in  1  system clock, the only clock.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NPORTS  access strobe per port, one cycle per CPU access.
- we  in  NPORTS  write enable, qualified by req.
- addr  in  NPORTS*ADDR_W  packed addresses, port i at [i*ADDR_W +: ADDR_W].
- wdata  in  NPORTS*DATA_W  packed write data.
- rdata  out  NPORTS*DATA_W  packed registered read data.
- rvalid  out  NPORTS  read-data valid pulse.
- firq_set  in  NPORTS  request FIRQ on the target given by firq_tgt.
- firq_tgt  in  NPORTS*2  packed target index per requester.
- firq_ack  in  NPORTS  target clears its own pending FIRQ.
- firq_n  out  NPORTS  active-low FIRQ level per port.
- coll_cnt  out  8  saturating count of dropped writes.

## Operation
- RAM has no reset. It is initialised to don't-care, and the bench must not rely on its contents.
- Read (req=1, we=0): rdata[i] <= mem[addr[i]]; rvalid[i] <= 1 for one cycle. rdata holds its value between reads.
- Write (req=1, we=1): the write commits at the clock edge. rvalid[i] stays 0.
- Read-first rule: a same-cycle read of an address being written by any port returns the pre-write value.
- Write-write collision (two or more ports write the same address in one cycle): only the highest-priority port commits. Each losing write increments coll_cnt by 1, saturating at 255. Writes to distinct addresses all commit.
- FIRQ mailbox: a pending[j] flag per port.
  - firq_set[i] with firq_tgt[i]=j sets pending[j].
  - firq_ack[j] clears pending[j].
  - If set and ack hit the same cycle, set wins (pending stays 1).
  - A self-target (j==i) is ignored.
  - A target index >= NPORTS is ignored.
  - Multiple setters of the same target in one cycle produce a single set.
- firq_n[j] = ~pending[j] and is registered, so no combinational path from inputs to firq_n.
- Per-port state is idle/access only. There is no multi-cycle handshake; a CPU must not assume any stall.

## Timing
- Reset values: rdata=0, rvalid=0, firq_n=all 1, coll_cnt=0, pending=0.
- Read latency is 1 cycle: req sampled at edge k, rdata/rvalid valid after edge k. This matches a 6809E E-cycle sampled 8 clk_20m cycles later.
- Write visible to reads issued at edge k+1 or later.
- firq_set at edge k causes firq_n low after edge k. firq_ack at edge m causes firq_n high after edge m.
- Reset assertion mid-access: rvalid and pending clear immediately (async). An in-flight write may or may not commit.
- Reset deassertion is synchronised internally: two-flop release on clk_20m before any state updates.

## Structure
- Package qix_pkg holds:
  - QIX_MAX_PORTS=4 and QIX_TGT_W=2.
  - A function that returns the priority rank of a port given HI_PRIO and NPORTS.
- Sub-module qix_firq_mbox: pending flags, target decode, set-over-ack priority, registered firq_n.
- Top level holds the RAM array (one write port per CPU via arbitrated write mux, with per-port registered read), collision detect and coll_cnt.
- RAM inference: for NPORTS=2, true dual-port M10K. For NPORTS>2, a per-port registered read of a single memory array is acceptable.

## Test plan
- NPORTS=2, reset then port0 writes 0xA5 @0x3FF, port1 reads 0x3FF next cycle -> rdata[1]=0xA5, rvalid[1]=1 for exactly one cycle.
- Same-cycle port0 write 0x11 @0x010 and port1 read @0x010, with prior content 0x22 -> rdata[1]=0x22; a read on the following cycle returns 0x11.
- HI_PRIO=1, both ports write @0x020 (port0 0x55, port1 0x66) -> mem=0x66, coll_cnt=1. Repeat 300 times -> coll_cnt=255.
- Port0 firq_set with tgt=1 -> firq_n[1]=0 next cycle. Port1 firq_ack and port0 firq_set in the same cycle -> firq_n[1] stays 0. Ack alone -> firq_n[1]=1.
- NPORTS=3: port2 firq_set with tgt=2 (self) and tgt=3 (out of range) -> all firq_n remain 1.
- Assert reset_n=0 while pending[0]=1 and coll_cnt=7 -> firq_n all 1, coll_cnt=0, rvalid=0 without waiting for a clock edge.
